// File: rtl/maple_pkg.sv
// Maple Bus shared definitions: FSM states, pattern lengths and start/end line-level tables.
package maple_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_GAP
    } tx_state_t;

    localparam int START_PHASES  = 10;
    localparam int END_PHASES    = 6;
    localparam int BITS_PER_BYTE = 8;

    // Bit i of each table is the line level during pattern phase i.
    localparam logic [START_PHASES-1:0] START_A = 10'b1000000000;
    localparam logic [START_PHASES-1:0] START_B = 10'b1101010101;
    localparam logic [END_PHASES-1:0]   END_A   = 6'b110101;
    localparam logic [END_PHASES-1:0]   END_B   = 6'b100000;

    // Returns {sdcka, sdckb} for one data phase; odd bits clock on A, even bits clock on B.
    function automatic logic [1:0] data_lines(input logic [7:0] data, input logic [3:0] phase);
        logic bit_val;
        logic clk_level;
        bit_val   = data[3'd7 - phase[3:1]];
        clk_level = ~phase[0];
        if (phase[1] == 1'b0) begin
            return {clk_level, bit_val};
        end
        return {bit_val, clk_level};
    endfunction

endpackage

// File: rtl/maple_tx_phy_if.sv
// Byte stream handshake between the TX FIFO and the Maple line encoder.
interface maple_tx_phy_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/maple_phase_timer.sv
// Waveform phase tick generator: counts 0..CLKS_PER_PHASE-1, ticks on terminal count, clearable.
module maple_phase_timer #(
    parameter int CLKS_PER_PHASE = 25
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_PHASE);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(CLKS_PER_PHASE - 1));

    always_ff @(posedge clk) begin
        if (srst || clr || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/maple_tx_phy.sv
// Maple Bus transmit encoder: byte stream -> SDCKA/SDCKB start, data, optional checksum, end.
// Build option MAPLE_TX_CRC_EN appends the XOR checksum byte after the tlast byte.
module maple_tx_phy
    import maple_pkg::*;
#(
    parameter int CLKS_PER_PHASE = 25,
    parameter int GAP_PHASES     = 4
) (
    input  logic          aclk,
    input  logic          areset,
    maple_tx_phy_if.slave s_axis,
    input  logic          enable,
    output logic          sdcka_o,
    output logic          sdckb_o,
    output logic          transmitting,
    output logic          underrun
);
    localparam int DATA_PHASES = 2 * BITS_PER_BYTE;
    localparam int PHASE_SPAN  = (GAP_PHASES > DATA_PHASES) ? GAP_PHASES : DATA_PHASES;
    localparam int PW          = $clog2(PHASE_SPAN);

    tx_state_t     state_reg, state_next;
    logic [PW-1:0] phase_reg;
    logic [7:0]    shift_reg;
    logic          last_reg;
    logic          tick;
    logic          accept;
    logic          abort;
    logic          byte_done;
    logic [1:0]    lines;

    maple_phase_timer #(.CLKS_PER_PHASE(CLKS_PER_PHASE)) u_timer (
        .clk  (aclk),
        .srst (areset),
        .clr  (state_next != state_reg),
        .tick (tick)
    );

    assign byte_done = tick && (phase_reg == PW'(DATA_PHASES - 1));

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable && s_axis.tvalid) begin
                    accept     = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick && phase_reg == PW'(START_PHASES - 1)) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (byte_done) begin
                    if (last_reg) begin
`ifdef MAPLE_TX_CRC_EN
                        state_next = ST_CRC;
`else
                        state_next = ST_END;
`endif
                    end else if (s_axis.tvalid) begin
                        accept = 1'b1;
                    end else begin
                        abort      = 1'b1;
                        state_next = ST_END;
                    end
                end
            end
`ifdef MAPLE_TX_CRC_EN
            ST_CRC: begin
                if (byte_done) state_next = ST_END;
            end
`endif
            ST_END: begin
                if (tick && phase_reg == PW'(END_PHASES - 1)) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (tick && phase_reg == PW'(GAP_PHASES - 1)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef MAPLE_TX_CRC_EN
    logic [7:0] crc_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            crc_reg <= '0;
        end else if (accept) begin
            crc_reg <= (state_reg == ST_IDLE) ? s_axis.tdata : (crc_reg ^ s_axis.tdata);
        end
    end
`endif

    always_comb begin
        lines = 2'b11;
        case (state_reg)
            ST_START: lines = {START_A[phase_reg[3:0]], START_B[phase_reg[3:0]]};
            ST_DATA:  lines = data_lines(shift_reg, phase_reg[3:0]);
`ifdef MAPLE_TX_CRC_EN
            ST_CRC:   lines = data_lines(crc_reg, phase_reg[3:0]);
`endif
            ST_END:   lines = {END_A[phase_reg[2:0]], END_B[phase_reg[2:0]]};
            default:  lines = 2'b11;
        endcase
    end

    assign sdcka_o       = lines[1];
    assign sdckb_o       = lines[0];
    assign transmitting  = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                           (state_reg == ST_CRC)   || (state_reg == ST_END);
    assign s_axis.tready = accept & ~areset;
    assign underrun      = abort & ~areset;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= ST_IDLE;
            phase_reg <= '0;
            shift_reg <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // A byte boundary inside DATA restarts the bit sequence without a state change.
            if (state_next != state_reg || (state_reg == ST_DATA && byte_done)) begin
                phase_reg <= '0;
            end else if (tick) begin
                phase_reg <= phase_reg + 1'b1;
            end
            if (accept) begin
                shift_reg <= s_axis.tdata;
                last_reg  <= s_axis.tlast;
            end
        end
    end
endmodule

// File: tb/tb_maple_tx_phy.sv
// Scoreboard bench for maple_tx_phy: random byte frames decoded from the line waveform.
`timescale 1ns/1ps
module tb_maple_tx_phy;
    localparam int CPP = 4;
    localparam int GAP = 4;
    localparam logic [1:0] START_EXP [10] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
                                              2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
    localparam logic [1:0] END_EXP [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic enable = 1'b1;
    logic sdcka_o, sdckb_o, transmitting, underrun;

    maple_tx_phy_if s_axis ();

    maple_tx_phy #(.CLKS_PER_PHASE(CPP), .GAP_PHASES(GAP)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis       (s_axis),
        .enable       (enable),
        .sdcka_o      (sdcka_o),
        .sdckb_o      (sdckb_o),
        .transmitting (transmitting),
        .underrun     (underrun)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    int         exp_rdy[$];
    int         exp_und[$];

    task automatic expect_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push_expect(input bit aborted);
        logic [7:0] crc;
        crc = 8'h00;
        foreach (frame_q[i]) begin
            exp_bytes.push_back(frame_q[i]);
            crc = crc ^ frame_q[i];
        end
`ifdef MAPLE_TX_CRC_EN
        if (!aborted) exp_bytes.push_back(crc);
        exp_len.push_back(frame_q.size() + (aborted ? 0 : 1));
`else
        exp_len.push_back(frame_q.size());
`endif
        exp_rdy.push_back(frame_q.size());
        exp_und.push_back(aborted ? 1 : 0);
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge aclk);
        while (!s_axis.tready && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axis.tready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tready=0 after %0d cycles, required 1", n);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic send_frame(input bit aborted);
        push_expect(aborted);
        for (int i = 0; i < frame_q.size(); i++) begin
            s_axis.tdata  = frame_q[i];
            s_axis.tlast  = !aborted && (i == frame_q.size() - 1);
            s_axis.tvalid = 1'b1;
            wait_accept();
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((exp_len.size() != 0 || transmitting) && n < 20000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d frames pending, required 0", exp_len.size());
        end
        repeat (GAP * CPP + 2) @(posedge aclk);
        #1;
    endtask

    // Monitor: captures each frame's line levels and decodes them by the bus rules.
    logic [1:0] samples[$];
    int rdy_cnt = 0, und_cnt = 0, cyc = 0, fall_cyc = 0;
    bit tx_prev = 1'b0, have_fall = 1'b0;

    task automatic check_frame();
        int n, r, u, bad_stable, bad_start, bad_end, bad_fall, nph;
        logic [1:0] ph[$];
        logic [1:0] first, second;
        logic [7:0] val, req;
        bit clk_a;
        logic clk1, clk2, dat1, dat2;
        if (exp_len.size() == 0) begin
            expect_eq("unexpected_frame", samples.size(), 0);
            return;
        end
        n = exp_len.pop_front();
        r = exp_rdy.pop_front();
        u = exp_und.pop_front();
        expect_eq("tx_cycles", samples.size(), CPP * (10 + 16 * n + 6));
        if (samples.size() != CPP * (10 + 16 * n + 6)) begin
            repeat (n) void'(exp_bytes.pop_front());
        end else begin
            nph = samples.size() / CPP;
            bad_stable = 0;
            for (int p = 0; p < nph; p++) begin
                ph.push_back(samples[p * CPP]);
                for (int k = 1; k < CPP; k++)
                    if (samples[p * CPP + k] != samples[p * CPP]) bad_stable++;
            end
            expect_eq("phase_stable", bad_stable, 0);
            bad_start = 0;
            for (int p = 0; p < 10; p++) if (ph[p] != START_EXP[p]) bad_start++;
            expect_eq("start_pattern", bad_start, 0);
            bad_end = 0;
            for (int p = 0; p < 6; p++) if (ph[nph - 6 + p] != END_EXP[p]) bad_end++;
            expect_eq("end_pattern", bad_end, 0);
            bad_fall = 0;
            for (int j = 0; j < n; j++) begin
                val = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    first  = ph[10 + 16 * j + 2 * k];
                    second = ph[10 + 16 * j + 2 * k + 1];
                    clk_a  = (k % 2 == 0);
                    clk1   = clk_a ? first[1] : first[0];
                    clk2   = clk_a ? second[1] : second[0];
                    dat1   = clk_a ? first[0] : first[1];
                    dat2   = clk_a ? second[0] : second[1];
                    if (!(clk1 == 1'b1 && clk2 == 1'b0 && dat1 == dat2)) bad_fall++;
                    val = {val[6:0], dat2};
                end
                req = exp_bytes.pop_front();
                expect_eq($sformatf("byte%0d", j), val, req);
            end
            expect_eq("clock_falls", bad_fall, 0);
        end
        expect_eq("tready_pulses", rdy_cnt, r);
        expect_eq("underrun_pulses", und_cnt, u);
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            if (areset) begin
                samples.delete();
                tx_prev = 1'b0;
                have_fall = 1'b0;
                rdy_cnt = 0;
                und_cnt = 0;
            end else begin
                cyc++;
                if (s_axis.tready && s_axis.tvalid) rdy_cnt++;
                if (underrun) und_cnt++;
                if (transmitting) begin
                    if (!tx_prev && have_fall)
                        expect_eq("gap_cycles_ok", int'(cyc - fall_cyc >= GAP * CPP + 1), 1);
                    samples.push_back({sdcka_o, sdckb_o});
                end else if (tx_prev) begin
                    fall_cyc = cyc;
                    have_fall = 1'b1;
                    check_frame();
                    samples.delete();
                    rdy_cnt = 0;
                    und_cnt = 0;
                end
                tx_prev = transmitting;
            end
        end
    end

    initial begin
        s_axis.tdata  = 8'h77;
        s_axis.tvalid = 1'b1;
        s_axis.tlast  = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        expect_eq("reset_lines", {sdcka_o, sdckb_o}, 2'b11);
        expect_eq("reset_transmitting", transmitting, 0);
        expect_eq("reset_tready", s_axis.tready, 0);
        expect_eq("reset_underrun", underrun, 0);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (3) @(posedge aclk);
        #1;

        frame_q = '{8'h01, 8'h02, 8'h03};
        send_frame(1'b0);
        frame_q = '{8'hA5};
        send_frame(1'b0);
        wait_drained();

        frame_q = '{8'h11};
        send_frame(1'b1);
        wait_drained();

        for (int f = 0; f < 8; f++) begin
            frame_q.delete();
            for (int i = 0; i < $urandom_range(1, 4); i++) frame_q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) @(posedge aclk);
                #1;
            end
            send_frame(1'b0);
        end
        wait_drained();

        enable = 1'b0;
        frame_q = '{8'h3C};
        push_expect(1'b0);
        s_axis.tdata  = 8'h3C;
        s_axis.tlast  = 1'b1;
        s_axis.tvalid = 1'b1;
        repeat (100) begin
            @(negedge aclk);
            expect_eq("disabled_hold", {s_axis.tready, sdcka_o, sdckb_o}, 3'b011);
        end
        @(posedge aclk);
        #1;
        enable = 1'b1;
        @(negedge aclk);
        expect_eq("tready_on_enable", s_axis.tready, 1);
        @(posedge aclk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        expect_eq("start_after_enable", transmitting, 1);
        wait_drained();

        s_axis.tdata  = 8'h5A;
        s_axis.tlast  = 1'b0;
        s_axis.tvalid = 1'b1;
        wait_accept();
        s_axis.tvalid = 1'b0;
        repeat ((10 + 7) * CPP + 1) @(posedge aclk);
        #1;
        expect_eq("pre_reset_transmitting", transmitting, 1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        expect_eq("midreset_lines", {sdcka_o, sdckb_o}, 2'b11);
        expect_eq("midreset_transmitting", transmitting, 0);
        expect_eq("midreset_tready", s_axis.tready, 0);
        expect_eq("midreset_underrun", underrun, 0);
        repeat (2) @(posedge aclk);
        #1;

        frame_q = '{8'hC3, 8'h81};
        send_frame(1'b0);
        wait_drained();
        expect_eq("scoreboard_drained", exp_len.size() + exp_bytes.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
